seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Parametrised multi-digit seven-segment scan controller; successor to the fixed 4-digit hex display driver.
- Replaces the external clock-divider tap with an internal prescaler running on the board clock.
- Adds a load handshake with a shadow register, per-digit decimal points, leading-zero blanking and an anti-ghosting dead cycle.
- Optionally adds binary-to-decimal display; sits between the processor result bus and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits and anodes; legal range 1..8.
- DATA_W, 4*NUM_DIGITS: width of data_in; must equal 4*NUM_DIGITS.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- ACTIVE_LOW, 1: 1 means seg, dp and an are driven active-low; 0 means active-high.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous reset, active-high.
- data_in  in  DATA_W  value to display; digit i = data_in[4i+3:4i], digit 0 is rightmost.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_lz into the shadow registers.
- dp_in  in  NUM_DIGITS  per-digit decimal point request.
- blank_lz  in  1  blank leading zero digits.
- busy  out  1  high while a load cannot be accepted.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0] = a.
- dp  out  1  decimal point of the active digit.
- an  out  NUM_DIGITS  anode enables, one-hot active.

Behaviour:
- Reset (async, rst=1), outputs go inactive immediately:
  - prescaler=0, digit index=0, shadow data/dp/blank=0, busy=0.
  - seg, dp and an all inactive: all 1s if ACTIVE_LOW, else all 0s.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted in the cycle the count equals REFRESH_DIV-1.
  - On tick, index advances; NUM_DIGITS-1 wraps to 0.
- Dead cycle: in the cycle after tick, all anodes are inactive (anti-ghosting). The new digit drives in the following cycle.
- Outputs are registered:
  - In any cycle, they reflect the index and shadow from the previous cycle.
  - After rst deasserts, digit 0 is driven on the first clk edge.
- Load handshake:
  - load=1 while busy=0: shadow updates on that edge and is visible on the next displayed digit.
  - load=1 while busy=1 is ignored.
  - load does not reset the prescaler or index.
- Hex encoding (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts seg, dp and an.
- Leading-zero blank:
  - If the blank shadow bit is set, digit k (k≥1) is blanked when digits NUM_DIGITS-1..k are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode inactive for its slot, dp included.
- dp = dp shadow bit of the active digit, unless forced by the optional feature.
- NUM_DIGITS=1: index stays 0; a dead cycle still occurs every tick.

Optional Feature:
- Macro: SEG_BCD_EN.
- Defined:
  - Adds input port dec_mode (1 bit).
  - load with dec_mode=1 while busy=0 starts a sequential double-dabble conversion of data_in into a 2*NUM_DIGITS-digit BCD register.
  - Timing: one shift per cycle over DATA_W cycles, and busy=1 for exactly DATA_W cycles starting the cycle after load. Shadow data, dp and blank update on the last cycle; busy falls the following cycle.
  - Lower NUM_DIGITS BCD digits are displayed.
  - If any upper BCD digit is nonzero (overflow), all digits' dp are forced active until the next completed load.
  - load with dec_mode=0 behaves as the hex load.
  - rst mid-conversion aborts the conversion; the shadow stays 0.
- Undefined: no dec_mode port; busy is tied 0; hex only.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1):
- Reset then load data_in=16'h12AF, dp_in=0 -> an cycles 1110, 1101, 1011, 0111 with one 1111 cycle after each tick; seg sequence ~71, ~77, ~5B, ~06; dp=1.
- load 16'h0040, blank_lz=1 -> digits 3 and 2 show an=1111 in their slots; digit 1 shows ~66, digit 0 shows ~3F.
- Hold load high for 3 cycles with changing data_in -> shadow holds the last sampled value; no prescaler or index disturbance (tick period stays 4).
- Assert rst mid-slot with digit 2 active -> an=1111 and seg=7F in the same cycle (async); digit 0 is driven on the first edge after release.
- SEG_BCD_EN, dec_mode=1, data_in=16'd1234 -> busy=1 for 16 cycles; load during busy is ignored; display shows 1,2,3,4 and dp=1.
- SEG_BCD_EN, dec_mode=1, data_in=16'd65535 -> display 5,5,3,5 and dp=0 (active) on every digit as the overflow indication.

Source files
------------

// File: rtl/seg_display_scan.sv
// seg_display_scan: parametrised multiplexed seven-segment scan controller.
// An internal prescaler steps a digit index once every REFRESH_DIV clocks and
// inserts one all-anodes-off cycle after each step to suppress ghosting.
// A shadow register (data, decimal points, blank flag) is loaded by a strobe.
// Leading zeros can be blanked, and all outputs are registered.
// Optional feature macro: SEG_BCD_EN. When it is defined, the block gains a
// dec_mode input and a sequential double-dabble binary-to-BCD converter.
// When SEG_BCD_EN is not defined, busy is tied low and the display is hex only.
module seg_display_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 4*NUM_DIGITS,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
`ifdef SEG_BCD_EN
    input  logic                  dec_mode,
`endif
    output logic                  busy,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Inactive levels depend on the board's drive polarity.
    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                           : {NUM_DIGITS{1'b0}};

    // Hex nibble to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick;

    // tick marks the last clock of a digit slot; the index steps on it.
    always_comb begin
        tick  = (cnt_q == CNT_W'(REFRESH_DIV-1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Scan timing state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow register and load acceptance
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]      dpm_q, dpm_d;
    logic                       blank_q, blank_d;
    logic                       hex_ld;
    logic                       ovf;

`ifdef SEG_BCD_EN
    localparam int CV_W  = $clog2(DATA_W+1);
    localparam int BCD_W = 8*NUM_DIGITS;

    logic [DATA_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic [CV_W-1:0]       bits_q, bits_d;
    logic                  busy_q, busy_d;
    logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
    logic                  pblank_q, pblank_d;
    logic                  ovf_q, ovf_d;
    logic                  bcd_start, bcd_done;

    // A load is only honoured while idle; dec_mode picks the conversion path.
    always_comb begin
        hex_ld    = load & ~dec_mode & ~busy_q;
        bcd_start = load &  dec_mode & ~busy_q;
        bcd_done  = busy_q & (bits_q == CV_W'(1));
    end

    // Double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 2*NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    // Converter sequencing: one shift per busy cycle, DATA_W cycles in total.
    always_comb begin
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        bits_d   = bits_q;
        busy_d   = busy_q;
        pdp_d    = pdp_q;
        pblank_d = pblank_q;
        if (bcd_start) begin
            bin_d    = data_in;
            bcd_d    = '0;
            bits_d   = CV_W'(DATA_W);
            busy_d   = 1'b1;
            pdp_d    = dp_in;
            pblank_d = blank_lz;
        end else if (busy_q) begin
            bin_d  = {bin_q[DATA_W-2:0], 1'b0};
            bcd_d  = bcd_shift;
            bits_d = bits_q - 1'b1;
            if (bcd_done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Overflow flag: any nonzero upper BCD digit; cleared by any completed load.
    always_comb begin
        ovf_d = ovf_q;
        if (hex_ld) begin
            ovf_d = 1'b0;
        end else if (bcd_done) begin
            ovf_d = |bcd_shift[BCD_W-1:4*NUM_DIGITS];
        end
    end

    // Converter and overflow state; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            bits_q   <= '0;
            busy_q   <= 1'b0;
            pdp_q    <= '0;
            pblank_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            bits_q   <= bits_d;
            busy_q   <= busy_d;
            pdp_q    <= pdp_d;
            pblank_q <= pblank_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
`else
    // Hex-only build: every load is accepted immediately.
    always_comb begin
        hex_ld = load;
    end

    assign busy = 1'b0;
    assign ovf  = 1'b0;
`endif

    // Shadow next-state: hex load or completed conversion (never both at once).
    always_comb begin
        data_d  = data_q;
        dpm_d   = dpm_q;
        blank_d = blank_q;
        if (hex_ld) begin
            data_d  = data_in;
            dpm_d   = dp_in;
            blank_d = blank_lz;
        end
`ifdef SEG_BCD_EN
        else if (bcd_done) begin
            data_d  = bcd_shift[4*NUM_DIGITS-1:0];
            dpm_d   = pdp_q;
            blank_d = pblank_q;
        end
`endif
    end

    // Shadow register holding what is currently shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dpm_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            dpm_q   <= dpm_d;
            blank_q <= blank_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask and output encoding
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    // Digit k is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_mask  = '0;
        zero_run = blank_q;
        for (int k = NUM_DIGITS-1; k >= 1; k--) begin
            zero_run   = zero_run & (data_q[k] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    logic [6:0]            seg_q, seg_d, seg_act;
    logic                  dp_q, dp_d, dp_act;
    logic [NUM_DIGITS-1:0] an_q, an_d, an_act;

    // Next output word: dark during the dead cycle and for blanked digits.
    always_comb begin
        seg_act = '0;
        dp_act  = 1'b0;
        an_act  = '0;
        if (!tick && !lz_mask[idx_q]) begin
            seg_act       = hex7(data_q[idx_q]);
            dp_act        = dpm_q[idx_q] | ovf;
            an_act[idx_q] = 1'b1;
        end
        seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
        dp_d  = ACTIVE_LOW ? ~dp_act  : dp_act;
        an_d  = ACTIVE_LOW ? ~an_act  : an_act;
    end

    // Output registers; reset forces every pin inactive immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan (4 digits, REFRESH_DIV=4, active-low).
// Expected digit slots are queued when a load is driven and compared mid-slot.
// The BCD checks are compiled in only when SEG_BCD_EN is defined.
module tb_seg_display_scan;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
`ifdef SEG_BCD_EN
    logic        dec_mode;
`endif
    logic        busy;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg_display_scan #(
        .NUM_DIGITS (4),
        .DATA_W     (16),
        .REFRESH_DIV(4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load),
        .dp_in   (dp_in),
        .blank_lz(blank_lz),
`ifdef SEG_BCD_EN
        .dec_mode(dec_mode),
`endif
        .busy    (busy),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_seg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   edges;

    // Edges since the last reset release: slot phase = edges % 4.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Queue the four slots that follow, starting at digit 'start'.
    task automatic push_scan(input logic [15:0] val, input logic [3:0] dpv,
                             input logic bl, input logic ovf, input int start);
        exp_t e;
        int   d;
        logic z;
        logic [3:0] oh;
        for (int s = 0; s < 4; s++) begin
            d = (start + s) % 4;
            z = bl && (d >= 1);
            for (int k = 3; k >= 1; k--) begin
                if (k >= d && val[4*k +: 4] != 4'h0) z = 1'b0;
            end
            oh = 4'b0001 << d;
            e.an      = z ? 4'hF : ~oh;
            e.seg     = ~hex7(val[4*d +: 4]);
            e.dp      = z ? 1'b1 : ~(dpv[d] | ovf);
            e.chk_seg = !z;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: dead cycle at phase 0, queued digit compared at phase 2.
    always @(negedge clk) begin
        if (!rst) begin
            if (edges % 4 == 0) begin
                chk("dead_an", {28'd0, an}, 32'hF);
            end else if (edges % 4 == 2 && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("slot_an", {28'd0, an}, {28'd0, mon_e.an});
                if (mon_e.chk_seg) chk("slot_seg", {25'd0, seg}, {25'd0, mon_e.seg});
                chk("slot_dp", {31'd0, dp}, {31'd0, mon_e.dp});
            end
        end
    end

    task automatic wait_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (edges % 4 == p) hit = 1'b1;
        end
        if (!hit) chk("phase_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    endtask

    // Hex load sampled on a slot-boundary edge.
    task automatic hex_load(input logic [15:0] val, input logic [3:0] dpv, input logic bl);
        wait_drain();
        wait_phase(3);
        data_in  = val;
        dp_in    = dpv;
        blank_lz = bl;
        load     = 1'b1;
        push_scan(val, dpv, bl, 1'b0, ((edges + 1) / 4) % 4);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

`ifdef SEG_BCD_EN
    task automatic bcd_load(input logic [15:0] val, input logic [15:0] shown, input logic ovf);
        int nb;
        wait_drain();
        wait_phase(3);
        data_in  = val;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        dec_mode = 1'b1;
        load     = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        dec_mode = 1'b0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (i == 0)  chk("busy_rise", {31'd0, busy}, 32'd1);
            if (i == 16) chk("busy_fall", {31'd0, busy}, 32'd0);
            if (i == 4) begin
                data_in = 16'hFFFF;
                load    = 1'b1;
            end
            if (i == 5) load = 1'b0;
        end
        chk("busy_len", nb, 16);
        push_scan(shown, 4'b0000, 1'b0, ovf, ((edges + 1) / 4) % 4);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
`ifdef SEG_BCD_EN
        dec_mode = 1'b0;
`endif
        #1;
        chk("rst_an",   {28'd0, an},   32'hF);
        chk("rst_seg",  {25'd0, seg},  32'h7F);
        chk("rst_dp",   {31'd0, dp},   32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_an",  {28'd0, an},  32'hE);
        chk("first_seg", {25'd0, seg}, {25'd0, ~7'h3F});

        hex_load(16'h12AF, 4'b0000, 1'b0);
        hex_load(16'h0040, 4'b0000, 1'b1);
        hex_load(16'h0000, 4'b0101, 1'b1);
        hex_load(16'h9E07, 4'b1000, 1'b1);

        // Load held for three edges; the last sample must win.
        wait_drain();
        wait_phase(1);
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        data_in  = 16'h1111;
        load     = 1'b1;
        @(negedge clk);
        data_in  = 16'h2222;
        @(negedge clk);
        data_in  = 16'h3456;
        push_scan(16'h3456, 4'b0000, 1'b0, 1'b0, ((edges + 1) / 4) % 4);
        @(posedge clk);
        #1 load = 1'b0;

        // Asynchronous reset while digit 2 is lit.
        wait_drain();
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 64 && !hit; i++) begin
                @(negedge clk);
                if (edges % 16 == 10) hit = 1'b1;
            end
            if (!hit) chk("digit2_timeout", 0, 1);
        end
        chk("pre_rst_an", {28'd0, an}, 32'hB);
        rst = 1'b1;
        #1;
        chk("async_an",  {28'd0, an},  32'hF);
        chk("async_seg", {25'd0, seg}, 32'h7F);
        chk("async_dp",  {31'd0, dp},  32'd1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_an",  {28'd0, an},  32'hE);
        chk("rel_seg", {25'd0, seg}, {25'd0, ~7'h3F});
        push_scan(16'h0000, 4'b0000, 1'b0, 1'b0, 0);

`ifdef SEG_BCD_EN
        bcd_load(16'd1234,  16'h1234, 1'b0);
        bcd_load(16'd65535, 16'h5535, 1'b1);
        hex_load(16'h0001, 4'b0000, 1'b0);
`endif

        wait_drain();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
